mul_result_buffer: RTL and testbench

MUL_RESULT_BUFFER -- requirements
Module: mul_result_buffer

---
 rtl/mul_result_buffer_pkg.sv | 32 +++
 rtl/mul_result_fifo.sv | 65 ++++++
 rtl/mul_result_buffer.sv | 115 +++++++++++
 tb/tb_mul_result_buffer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_result_buffer_pkg.sv
// Shared definitions for the multiplier result buffer: precision-derived
// field widths, result-flag bit positions and the issue-tag width.
package mul_result_buffer_pkg;

  // IEEE-754 field widths for the two supported precisions
  localparam int SP_EXP_W  = 8;
  localparam int SP_MANT_W = 23;
  localparam int DP_EXP_W  = 11;
  localparam int DP_MANT_W = 52;

  // Result classification flags, stored alongside each buffered result
  localparam int FLAGS_W   = 5;
  localparam int FLAG_NAN  = 4;
  localparam int FLAG_INF  = 3;
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_SUB  = 1;
  localparam int FLAG_SIGN = 0;

  // Issue sequence number carried with every result
  localparam int TAG_W = 2;

  // Exponent width for the selected precision
  function automatic int exp_width(input int is_double);
    return (is_double != 0) ? DP_EXP_W : SP_EXP_W;
  endfunction

  // Stored mantissa width for the selected precision
  function automatic int mant_width(input int is_double);
    return (is_double != 0) ? DP_MANT_W : SP_MANT_W;
  endfunction

endpackage

// File: rtl/mul_result_fifo.sv
// Result storage for the multiplier buffer: DEPTH-entry circular FIFO with
// wrapping pointers and an occupancy count. The read port is the register
// at rd_ptr, so the head entry holds steady until it is popped.
module mul_result_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Entry storage; cleared on reset so the head reads zero afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy: a simultaneous write and pop leaves the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/mul_result_buffer.sv
// Multiplier front end with a credit-checked result FIFO. Operands pass
// straight to a 1-cycle multiplier; an operand pair is only accepted when a
// FIFO slot is guaranteed for its result, so results are never dropped.
// Each result is classified and tagged with its issue number on entry.
module mul_result_buffer
  import mul_result_buffer_pkg::*;
#(
  parameter int IS_DOUBLE   = 0,
  parameter int EXP_WIDTH   = exp_width(IS_DOUBLE),
  parameter int MANT_WIDTH  = mant_width(IS_DOUBLE),
  parameter int TOTAL_WIDTH = EXP_WIDTH + MANT_WIDTH + 1,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TOTAL_WIDTH-1:0]   in_op1,
  input  logic [TOTAL_WIDTH-1:0]   in_op2,
  output logic [TOTAL_WIDTH-1:0]   mul_op1,
  output logic [TOTAL_WIDTH-1:0]   mul_op2,
  input  logic [TOTAL_WIDTH-1:0]   mul_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TOTAL_WIDTH-1:0]   out_result,
  output logic [FLAGS_W-1:0]       out_flags,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = TAG_W + FLAGS_W + TOTAL_WIDTH;

  logic               accept;
  logic               pop;
  logic               inflight;
  logic [TAG_W-1:0]   inflight_tag;
  logic [TAG_W-1:0]   tag_cnt;
  logic [CNT_W:0]     credit_used;
  logic [FLAGS_W-1:0] wr_flags;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  // Classify a value into {nan, inf, zero, subnormal, sign}
  function automatic logic [FLAGS_W-1:0] classify(input logic [TOTAL_WIDTH-1:0] v);
    logic [EXP_WIDTH-1:0]  e;
    logic [MANT_WIDTH-1:0] m;
    logic                  exp_ones;
    logic                  exp_zero;
    logic                  mant_zero;
    logic [FLAGS_W-1:0]    f;
    e         = v[TOTAL_WIDTH-2 -: EXP_WIDTH];
    m         = v[MANT_WIDTH-1:0];
    exp_ones  = &e;
    exp_zero  = ~|e;
    mant_zero = ~|m;
    f            = '0;
    f[FLAG_NAN]  = exp_ones & ~mant_zero;
    f[FLAG_INF]  = exp_ones & mant_zero;
    f[FLAG_ZERO] = exp_zero & mant_zero;
    f[FLAG_SUB]  = exp_zero & ~mant_zero;
    f[FLAG_SIGN] = v[TOTAL_WIDTH-1];
    return f;
  endfunction

  assign mul_op1 = in_op1;
  assign mul_op2 = in_op2;

  // Slots already promised = stored results plus the one in the multiplier
  assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign in_ready    = (credit_used < (CNT_W + 1)'(DEPTH));
  assign accept      = in_valid & in_ready;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;

  // Track the multiplier stage and hand out issue tags in acceptance order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight     <= 1'b0;
      inflight_tag <= '0;
      tag_cnt      <= '0;
    end else begin
      inflight <= accept;
      if (accept) begin
        inflight_tag <= tag_cnt;
        tag_cnt      <= tag_cnt + TAG_W'(1);
      end
    end
  end

  // Flags are computed once, as the result enters the FIFO
  always_comb begin
    wr_flags = classify(mul_result);
    wr_entry = {inflight_tag, wr_flags, mul_result};
  end

  mul_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (inflight),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (rd_entry),
    .count   (count)
  );

  assign out_tag    = rd_entry[ENTRY_W-1 -: TAG_W];
  assign out_flags  = rd_entry[TOTAL_WIDTH +: FLAGS_W];
  assign out_result = rd_entry[TOTAL_WIDTH-1:0];

endmodule

// File: tb/tb_mul_result_buffer.sv
// Self-checking bench for mul_result_buffer (single precision, DEPTH 4).
// A behavioural 1-cycle multiplier feeds the DUT; accepted operand pairs push
// their expected result/flags/tag to a scoreboard that is checked on pop.
module tb_mul_result_buffer;

  localparam int W     = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_op1;
  logic [W-1:0]  in_op2;
  logic [W-1:0]  mul_op1;
  logic [W-1:0]  mul_op2;
  logic [W-1:0]  mul_result = 32'h0000_0000;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [4:0]    out_flags;
  logic [1:0]    out_tag;
  logic [2:0]    count;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] res;
    logic [4:0]  flags;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flags;
    logic [1:0]  tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  vec_t        vecs[10];
  int          n_cmp = 0;
  int          n_err = 0;
  int          acc_total = 0;
  int          acc_base;
  logic [31:0] cur_res;
  logic [4:0]  cur_flags;
  logic [1:0]  tag_model;
  logic        prev_stall = 1'b0;
  logic [38:0] hold_val;

  always #5 clk = ~clk;

  mul_result_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op1     (in_op1),
    .in_op2     (in_op2),
    .mul_op1    (mul_op1),
    .mul_op2    (mul_op2),
    .mul_result (mul_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_tag    (out_tag),
    .count      (count)
  );

  // Stand-in multiplier: exact for x*1.0 and 2.0*3.0, arbitrary otherwise
  function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h3F80_0000) return a;
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    return a ^ b;
  endfunction

  // Registered multiplier result, one cycle after the operands
  always @(posedge clk) mul_result <= mul_model(mul_op1, mul_op2);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor at the falling edge: record accepts, check pops and head stability
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid)
        chk("hold_stable", {25'd0, out_tag, out_flags, out_result}, {25'd0, hold_val});
      if (in_valid && in_ready) begin
        sb.push_back('{cur_res, cur_flags, tag_model});
        tag_model = tag_model + 2'd1;
        acc_total++;
      end
      if (out_valid && out_ready) begin
        chk("pop_has_expect", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("pop_result", 64'(out_result), 64'(e.res));
          chk("pop_flags",  64'(out_flags),  64'(e.flags));
          chk("pop_tag",    64'(out_tag),    64'(e.tag));
        end
      end
      prev_stall = out_valid && !out_ready;
      hold_val   = {out_tag, out_flags, out_result};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic [4:0] f);
    in_op1    = a;
    in_op2    = b;
    cur_res   = r;
    cur_flags = f;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    tag_model = 2'd0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 5'b00000};
    vecs[1] = '{32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 5'b10000};
    vecs[2] = '{32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 5'b01001};
    vecs[3] = '{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 5'b00101};
    vecs[4] = '{32'h0000_0001, 32'h3F80_0000, 32'h0000_0001, 5'b00010};
    vecs[5] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 5'b00000};
    vecs[6] = '{32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 5'b01000};
    vecs[7] = '{32'hC000_0000, 32'h3F80_0000, 32'hC000_0000, 5'b00001};
    vecs[8] = '{32'h807F_FFFF, 32'h3F80_0000, 32'h807F_FFFF, 5'b00011};
    vecs[9] = '{32'hFFFF_FFFF, 32'h3F80_0000, 32'hFFFF_FFFF, 5'b10001};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op1 = 32'h0; in_op2 = 32'h0; cur_res = 32'h0; cur_flags = 5'd0; tag_model = 2'd0;
    repeat (3) step();

    // Reset state
    chk("rst_out_valid",  64'(out_valid),  64'd0);
    chk("rst_count",      64'(count),      64'd0);
    chk("rst_in_ready",   64'(in_ready),   64'd1);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_flags",  64'(out_flags),  64'd0);
    chk("rst_out_tag",    64'(out_tag),    64'd0);
    rst_n = 1'b1;
    step();

    // Single multiply: 2.0 x 3.0, out_valid two cycles after the accept cycle
    out_ready = 1'b1;
    drive(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 5'b00000);
    in_valid = 1'b1;
    @(negedge clk);
    chk("mul_op1_pass", 64'(mul_op1), 64'h4000_0000);
    chk("mul_op2_pass", 64'(mul_op2), 64'h4040_0000);
    step();
    in_valid = 1'b0;
    in_op1 = 32'h1234_5678;
    #1;
    chk("mul_op1_no_hs", 64'(mul_op1), 64'h1234_5678);
    @(negedge clk);
    chk("latency_cycle1", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("latency_cycle2", 64'(out_valid), 64'd1);
    step();
    drain("single_drain");

    // Table of classification vectors, streamed one per cycle
    acc_base = acc_total;
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].op1, vecs[i].op2, vecs[i].res, vecs[i].flags);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("table_accepted", 64'(acc_total - acc_base), 64'd10);
    drain("table_drain");

    // Back-pressure: fill to DEPTH with the consumer stalled
    do_reset();
    out_ready = 1'b0;
    acc_base  = acc_total;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(32'h4100_0000 + 32'(i), 32'h3F80_0000, 32'h4100_0000 + 32'(i), 5'b00000);
      step();
    end
    chk("bp_accepts",  64'(acc_total - acc_base), 64'd4);
    chk("bp_count",    64'(count),    64'd4);
    chk("bp_in_ready", 64'(in_ready), 64'd0);

    // Full with the consumer resuming: one pop per cycle, credit returns
    drive(32'h4200_0000, 32'h3F80_0000, 32'h4200_0000, 5'b00000);
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_ready_before_pop", 64'(in_ready), 64'd0);
    step();
    @(negedge clk);
    chk("ready_after_pop", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    drain("full_drain");
    chk("full_accepts", 64'(acc_total - acc_base), 64'd5);

    // Reset mid-flight with two stored results and one in the multiplier
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h4300_0000 + 32'(i), 32'h3F80_0000, 32'h4300_0000 + 32'(i), 5'b00000);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_count_before", 64'(count), 64'd2);
    #1;
    rst_n = 1'b0;
    sb.delete();
    tag_model = 2'd0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_count",     64'(count),     64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("mid_post_count", 64'(count), 64'd0);
    out_ready = 1'b1;
    drive(32'h4228_0000, 32'h3F80_0000, 32'h4228_0000, 5'b00000);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    drain("mid_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
